// File: rtl/dmem_bridge_pkg.sv
// Shared types and constants for the data-memory bridge.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dmem_state_e;

    localparam logic [3:0] BE_WORD = 4'hF;
    localparam int         CNT_W   = 16;

endpackage

// File: rtl/dmem_bridge_if.sv
// Wait-stated data memory bus: req/ack handshake with byte-lane enables.
interface dmem_bridge_if;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic        bus_err;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_ack, bus_err, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_ack, bus_err, bus_rdata
    );

endinterface

// File: rtl/dmem_bridge_lane.sv
// Byte-lane steering: enables and replicated write data toward the bus,
// lane extraction and zero-extension for load results.
module dmem_lane
    import dmem_pkg::*;
(
    input  logic        i_byte,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    // Word accesses pass straight through; byte accesses pick one lane.
    always_comb begin
        o_be    = BE_WORD;
        o_wdata = i_wdata;
        o_rdata = i_rdata;
        if (i_byte) begin
            o_be    = 4'b0001 << i_addr_lo;
            o_wdata = {4{i_wdata[7:0]}};
            case (i_addr_lo)
                2'd0:    o_rdata = {24'd0, i_rdata[7:0]};
                2'd1:    o_rdata = {24'd0, i_rdata[15:8]};
                2'd2:    o_rdata = {24'd0, i_rdata[23:16]};
                default: o_rdata = {24'd0, i_rdata[31:24]};
            endcase
        end
    end

endmodule

// File: rtl/dmem_bridge.sv
// Data-memory bridge: turns single-cycle datapath loads/stores into
// req/ack bus transactions and stalls the core while one is outstanding.
//
//   state | meaning
//   IDLE  | waiting for MemRead/MemWrite; request cycle stalls combinationally
//   BUSY  | bus_req high, waiting for ack or timeout
//   DONE  | result/fault presented for one cycle, stall released
module dmem_bridge
    import dmem_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MemRead,
    input  logic          MemWrite,
    input  logic          MemByte,
    input  logic [31:0]   ALUResult,
    input  logic [31:0]   WriteData,
    output logic [31:0]   ReadData,
    output logic          Stall,
    output logic          MemFault,
    dmem_bridge_if.master bus
);

    localparam logic [CNT_W:0] TO_VAL = (CNT_W + 1)'(TIMEOUT);

    dmem_state_e       r_state;
    dmem_state_e       w_state_nxt;
    logic [31:0]       r_addr;
    logic              r_we;
    logic              r_byte;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              r_fault;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_access;
    logic              w_misalign;
    logic              w_timeout;
    logic              w_bus_req;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [31:0]       w_rdata;

    assign w_access   = MemRead | MemWrite;
    assign w_misalign = ~MemByte & (ALUResult[1:0] != 2'b00);
    assign w_timeout  = (({1'b0, r_cnt} + 17'd1) == TO_VAL);

    // State register; reset also kills an in-flight request at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        Stall       = 1'b0;
        w_bus_req   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_access) begin
                    Stall       = 1'b1;
                    w_state_nxt = w_misalign ? DONE : BUSY;
                end
            end
            BUSY: begin
                Stall     = 1'b1;
                w_bus_req = 1'b1;
                if (bus.bus_ack || w_timeout) w_state_nxt = DONE;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Access latches, wait counter and captured response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_byte  <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_fault <= 1'b0;
            r_cnt   <= '0;
        end else if (r_state == IDLE) begin
            if (w_access) begin
                r_addr  <= ALUResult;
                r_we    <= MemWrite;
                r_byte  <= MemByte;
                r_wdata <= WriteData;
                r_rdata <= '0;
                r_fault <= w_misalign;
                r_cnt   <= '0;
            end
        end else if (r_state == BUSY) begin
            r_cnt <= r_cnt + 1'b1;
            if (bus.bus_ack) begin
                r_rdata <= bus.bus_rdata;
                r_fault <= bus.bus_err;
            end else if (w_timeout) begin
                r_rdata <= '0;
                r_fault <= 1'b1;
            end
        end
    end

    dmem_lane u_lane (
        .i_byte    (r_byte),
        .i_addr_lo (r_addr[1:0]),
        .i_wdata   (r_wdata),
        .i_rdata   (r_rdata),
        .o_be      (w_be),
        .o_wdata   (w_wdata),
        .o_rdata   (w_rdata)
    );

    // Bus fields are only live while requesting so they read as 0 otherwise.
    assign bus.bus_req   = w_bus_req;
    assign bus.bus_we    = w_bus_req & r_we;
    assign bus.bus_addr  = w_bus_req ? {r_addr[31:2], 2'b00} : 32'd0;
    assign bus.bus_wdata = w_bus_req ? w_wdata : 32'd0;
    assign bus.bus_be    = w_bus_req ? w_be : 4'd0;

    assign ReadData = (r_state == DONE && !r_fault && !r_we) ? w_rdata : 32'd0;
    assign MemFault = (r_state == DONE) & r_fault;

endmodule

// File: tb/tb_dmem_bridge.sv
// Bench for dmem_bridge: bus slave with programmable wait states, expected
// load results queued at issue and compared when the bridge reaches DONE.
module tb_dmem_bridge;
    import dmem_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_read, mem_write, mem_byte;
    logic [31:0] alu_result, write_data;
    logic [31:0] read_data;
    logic        stall, mem_fault;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    dmem_bridge_if bus ();

    dmem_bridge #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemRead   (mem_read),
        .MemWrite  (mem_write),
        .MemByte   (mem_byte),
        .ALUResult (alu_result),
        .WriteData (write_data),
        .ReadData  (read_data),
        .Stall     (stall),
        .MemFault  (mem_fault),
        .bus       (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic run_access(input string nm, input logic rd, input logic wr,
                              input logic byt, input logic [31:0] addr,
                              input logic [31:0] wdat, input int wait_n,
                              input logic [31:0] rdat, input logic err,
                              input logic no_ack, input logic err_noise);
        logic        misal;
        logic [3:0]  e_be;
        logic [31:0] e_wdata, e_rd, e_addr;
        logic        e_fault;
        int          e_stall, e_req, stall_n, req_n;
        bit          done;
        exp_t        e;

        misal   = !byt && (addr[1:0] != 2'b00);
        e_addr  = {addr[31:2], 2'b00};
        e_be    = 4'hF;
        e_wdata = wdat;
        e_rd    = rdat;
        if (byt) begin
            e_wdata = {wdat[7:0], wdat[7:0], wdat[7:0], wdat[7:0]};
            case (addr[1:0])
                2'd0:    begin e_be = 4'b0001; e_rd = {24'd0, rdat[7:0]};   end
                2'd1:    begin e_be = 4'b0010; e_rd = {24'd0, rdat[15:8]};  end
                2'd2:    begin e_be = 4'b0100; e_rd = {24'd0, rdat[23:16]}; end
                default: begin e_be = 4'b1000; e_rd = {24'd0, rdat[31:24]}; end
            endcase
        end
        e_fault = misal || no_ack || err;
        if (e_fault || wr) e_rd = 32'd0;
        e_stall = misal ? 1 : (no_ack ? TO + 1 : wait_n + 2);
        e_req   = misal ? 0 : (no_ack ? TO : wait_n + 1);
        e.rdata = e_rd;
        e.fault = e_fault;
        sb_q.push_back(e);

        @(posedge clk); #1;
        mem_read   = rd;
        mem_write  = wr;
        mem_byte   = byt;
        alu_result = addr;
        write_data = wdat;
        stall_n = 0;
        req_n   = 0;
        done    = 0;

        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            bus.bus_ack   = 1'b0;
            bus.bus_err   = 1'b0;
            bus.bus_rdata = 32'd0;
            if (!stall) begin
                done = 1;
                break;
            end
            stall_n++;
            chk({nm, "_fault_early"}, 32'(mem_fault), 32'd0);
            if (bus.bus_req) begin
                req_n++;
                chk({nm, "_we"},    32'(bus.bus_we), 32'(wr));
                chk({nm, "_addr"},  bus.bus_addr, e_addr);
                chk({nm, "_be"},    32'(bus.bus_be), 32'(e_be));
                chk({nm, "_wdata"}, bus.bus_wdata, e_wdata);
                if (!no_ack && req_n == wait_n + 1) begin
                    bus.bus_ack   = 1'b1;
                    bus.bus_err   = err;
                    bus.bus_rdata = rdat;
                end else if (err_noise) begin
                    bus.bus_err   = 1'b1;
                    bus.bus_rdata = 32'hBAD0_BAD0;
                end
            end
        end

        chk({nm, "_done_seen"}, 32'(done), 32'd1);
        e = sb_q.pop_front();
        if (done) begin
            chk({nm, "_rdata"},    read_data, e.rdata);
            chk({nm, "_memfault"}, 32'(mem_fault), 32'(e.fault));
            chk({nm, "_req_done"}, 32'(bus.bus_req), 32'd0);
            chk({nm, "_stall_n"},  32'(stall_n), 32'(e_stall));
            chk({nm, "_req_n"},    32'(req_n), 32'(e_req));
        end

        @(posedge clk); #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_byte  = 1'b0;
        @(negedge clk);
        chk({nm, "_idle_stall"}, 32'(stall), 32'd0);
        chk({nm, "_idle_fault"}, 32'(mem_fault), 32'd0);
        chk({nm, "_idle_req"},   32'(bus.bus_req), 32'd0);
    endtask

    initial begin
        int waited;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_byte      = 1'b0;
        alu_result    = 32'd0;
        write_data    = 32'd0;
        bus.bus_ack   = 1'b0;
        bus.bus_err   = 1'b0;
        bus.bus_rdata = 32'd0;

        #2;
        chk("rst_rdata",  read_data, 32'd0);
        chk("rst_stall",  32'(stall), 32'd0);
        chk("rst_fault",  32'(mem_fault), 32'd0);
        chk("rst_req",    32'(bus.bus_req), 32'd0);
        chk("rst_we",     32'(bus.bus_we), 32'd0);
        chk("rst_addr",   bus.bus_addr, 32'd0);
        chk("rst_wdata",  bus.bus_wdata, 32'd0);
        chk("rst_be",     32'(bus.bus_be), 32'd0);

        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);

        //          name        rd wr  byt addr          wdata         wait rdata         err nack noise
        run_access("wload",     1, 0,  0, 32'h0000_0100, 32'h0,        2,  32'hDEAD_BEEF, 0,  0,   0);
        run_access("bstore",    0, 1,  1, 32'h0000_0203, 32'h1234_5678, 0, 32'h5555_AAAA, 0,  0,   0);
        run_access("bload2",    1, 0,  1, 32'h0000_0102, 32'h0,        1,  32'hAABB_CCDD, 0,  0,   0);
        run_access("misalign",  1, 0,  0, 32'h0000_0101, 32'h0,        0,  32'h0,         0,  0,   0);
        run_access("timeout",   1, 0,  0, 32'h0000_0040, 32'h0,        0,  32'h0,         0,  1,   0);
        run_access("st_err",    0, 1,  0, 32'h0000_0044, 32'hCAFE_0001, 1, 32'h0,         1,  0,   1);
        run_access("lastack",   1, 0,  1, 32'h0000_0003, 32'h0,        3,  32'h1122_3344, 0,  0,   1);
        run_access("bload0",    1, 1,  1, 32'h0000_0080, 32'h0000_00A5, 0, 32'hCAFE_F00D, 0,  0,   0);
        run_access("bload0r",   1, 0,  1, 32'h0000_0080, 32'h0,        0,  32'hCAFE_F00D, 0,  0,   0);
        run_access("mis_st",    0, 1,  0, 32'h0000_0206, 32'hFFFF_FFFF, 0, 32'h0,         0,  0,   0);

        // Reset while BUSY, then a late ack must be ignored.
        @(posedge clk); #1;
        mem_read   = 1'b1;
        alu_result = 32'h0000_0300;
        waited     = 0;
        while (waited < 20) begin
            @(negedge clk);
            if (bus.bus_req) break;
            waited++;
        end
        chk("rst_busy_reached", 32'(bus.bus_req), 32'd1);
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_mid_req",   32'(bus.bus_req), 32'd0);
        chk("rst_mid_fault", 32'(mem_fault), 32'd0);
        mem_read = 1'b0;
        #1;
        chk("rst_mid_idle",  32'(stall), 32'd0);
        bus.bus_ack   = 1'b1;
        bus.bus_rdata = 32'h0BAD_F00D;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("late_ack_stall", 32'(stall), 32'd0);
            chk("late_ack_fault", 32'(mem_fault), 32'd0);
            chk("late_ack_req",   32'(bus.bus_req), 32'd0);
            chk("late_ack_rdata", read_data, 32'd0);
        end
        bus.bus_ack   = 1'b0;
        bus.bus_rdata = 32'd0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Data-memory bridge between the single-cycle ARM datapath and a wait-stated data memory bus. It sits directly downstream of the datapath and consumes its ALUResult address and WriteData. It runs each LDR/STR/LDRB/STRB as a req/ack bus transaction and returns ReadData to the datapath's result mux. While a transaction is outstanding it asserts Stall, which gates the PC register and register-file write enable.

## Interface
- TIMEOUT, 255: maximum BUSY cycles waiting for bus_ack before the access is aborted; legal range 1..65535.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low (low = reset).
- MemRead  in  1  the current instruction is a load.
- MemWrite  in  1  the current instruction is a store; takes precedence if MemRead is also high.
- MemByte  in  1  byte access (LDRB/STRB); 0 = word.
- ALUResult  in  32  byte address from the datapath.
- WriteData  in  32  store data from the datapath.
- ReadData  out  32  load result to the datapath result mux.
- Stall  out  1  holds PC and blocks RegWrite this cycle.
- MemFault  out  1  one-cycle pulse when an access completes abnormally.
- bus_req  out  1  transaction request.
- bus_we  out  1  1 = write.
- bus_addr  out  32  word address; bits [1:0] are always 0.
- bus_wdata  out  32  write data.
- bus_be  out  4  byte-lane enables.
- bus_ack  in  1  transaction complete; sampled only while bus_req is high.
- bus_err  in  1  error qualifier; valid only with bus_ack.
- bus_rdata  in  32  read data; valid only with bus_ack.

## Operation
- The FSM has three states: IDLE, BUSY and DONE. Reset puts it in IDLE.
- IDLE, no access (MemRead=MemWrite=0):
  - Stall=0, ReadData=0, bus_req=0.
- IDLE with an access:
  - Stall=1 combinationally in the same cycle.
  - Latch the address, direction, byte enables and write data.
  - If the access is a word access and ALUResult[1:0]≠0, go to DONE with the fault flag set. No bus transaction is issued.
  - Otherwise go to BUSY.
- BUSY:
  - bus_req=1 and Stall=1. All bus outputs are driven from the latches and held stable.
  - The cycle counter increments every BUSY cycle.
  - On bus_ack=1: capture bus_rdata, set fault=bus_err, go to DONE.
  - If the counter reaches TIMEOUT with no ack: fault=1, rdata=0, go to DONE.
- DONE:
  - Stall=0, and ReadData = extracted captured data (0 on fault).
  - MemFault = fault for this cycle only.
  - The datapath completes the instruction in this cycle. The FSM returns to IDLE unconditionally, so the held access is never reissued.
- Byte lanes:
  - Word access: be=4'hF and wdata=WriteData. ReadData is the full word.
  - Byte access: be = 4'b0001 << addr[1:0]. wdata = WriteData[7:0] replicated across all four lanes. ReadData = the selected lane, zero-extended to 32 bits.
- Stores:
  - Stores go through the same FSM. ReadData in DONE is don't-care and is driven to 0.
  - bus_err on a store pulses MemFault; there is no retry.
- bus_ack while bus_req=0 is ignored.
- bus_err without bus_ack is ignored.

## Timing
- Reset values of all outputs are 0: ReadData, Stall, MemFault, bus_req, bus_we, bus_addr, bus_wdata, bus_be.
- Reset asserted mid-transaction drops bus_req immediately (asynchronously), returns the FSM to IDLE, and does not pulse MemFault.
- Minimum access (ack in the first BUSY cycle) takes 3 cycles: IDLE(Stall=1), BUSY(req, ack), DONE. Stall is high for 2 cycles.
- An ack after N BUSY cycles gives a latency of N+2 cycles.
- A misaligned word access takes 2 cycles: IDLE(Stall=1), then DONE(MemFault=1).
- bus_req drops in the cycle after ack is sampled; it never stays high in DONE.
- Timeout: abort on the TIMEOUT-th BUSY cycle without ack. The counter is 16 bits and cleared on entry to BUSY.
- Back-to-back accesses: there is always at least one IDLE cycle between two transactions. That IDLE cycle is the next instruction's request cycle.

## Structure
- A shared package dmem_pkg holds:
  - the state enum (IDLE, BUSY, DONE);
  - BE_WORD = 4'hF;
  - the TIMEOUT counter width constant (16).
- Sub-module dmem_lane is purely combinational. Inputs: byte flag, addr[1:0], WriteData, captured rdata. Outputs: be, wdata, extracted ReadData.
- The top level contains only the FSM, the latches and the counter.

## Test plan
- Word load, memory acks after 2 wait cycles, addr 0x100, rdata 0xDEADBEEF → bus_addr=0x100, be=F, Stall high 4 cycles, ReadData=0xDEADBEEF in DONE, MemFault=0.
- Byte store, addr 0x203, WriteData 0x12345678 → bus_addr=0x200, be=4'b1000, bus_wdata=0x78787878, bus_we=1.
- Byte load, addr 0x102, rdata 0xAABBCCDD → ReadData=0x000000BB.
- Word load at 0x101 → no bus_req, DONE on cycle 2, MemFault=1, ReadData=0.
- Never ack, TIMEOUT=4 → bus_req high exactly 4 cycles, then DONE with MemFault=1 and bus_req=0.
- Reset pulled low in BUSY, then ack arrives → bus_req=0 immediately, FSM in IDLE, late ack ignored, MemFault stays 0.
